// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo: one write port, one synchronous
// read port. The array itself is never reset so it maps onto distributed RAM;
// only the read data register is reset.
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: storage is intentionally left without a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: sampling before the write lands gives old data when a full
    // FIFO pushes and pops the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and sticky
// overflow/underflow flags. Pointers wrap naturally; count is kept separately
// so full and empty are unambiguous.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             rd_valid,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full FIFO is allowed only when a pop frees a slot the
    // same cycle; a pop from empty is never accepted (no bypass).
    assign push_ok = wr_en & (~full | rd_en);
    assign pop_ok  = rd_en & ~empty;

    // Next occupancy, used to register count and the full/empty decodes.
    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_next = count - CNT_ONE;
        end
    end

    // Pointers, count, status flags and read-valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == CNT_FULL);
            rd_valid <= pop_ok;
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

endmodule
